// File: rtl/cute_key_sequencer.sv
// Key schedule sequencer for counter-locked cores: stores one key per phase and
// replays it on keyinput in lockstep with the core's phase counter, blanking on misalignment.
module cute_key_sequencer #(
  parameter int KEY_WIDTH  = 3,
  parameter int NUM_PHASES = 4,
  parameter int PHASE_W    = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [PHASE_W-1:0]   cfg_index,
  input  logic [KEY_WIDTH-1:0] cfg_key,
  input  logic                 start,
  input  logic                 stop,
  input  logic [PHASE_W-1:0]   lock_phase,
  output logic [KEY_WIDTH-1:0] key_out,
  output logic                 running,
  output logic                 loaded,
  output logic                 err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  state_t                state_r, state_s;
  logic [KEY_WIDTH-1:0]  key_r, key_s;
  logic [PHASE_W-1:0]    mirror_r, mirror_s;
  logic                  err_r, err_s;
  logic [NUM_PHASES-1:0] mask_r, mask_s;
  logic                  loaded_r;
  logic                  wr_s;
  logic [PHASE_W-1:0]    lock_next_s, mirror_next_s;
  logic [KEY_WIDTH-1:0]  sched_r [NUM_PHASES];

  assign wr_s          = cfg_valid && (state_r == ST_IDLE);
  assign lock_next_s   = lock_phase + PHASE_W'(1);
  assign mirror_next_s = mirror_r + PHASE_W'(1);

  // Next-state and next-output decode
  always_comb begin
    state_s  = state_r;
    key_s    = {KEY_WIDTH{1'b0}};
    mirror_s = mirror_r;
    err_s    = err_r;
    if (wr_s) begin
      mask_s = mask_r | ({{(NUM_PHASES-1){1'b0}}, 1'b1} << cfg_index);
    end else begin
      mask_s = mask_r;
    end
    case (state_r)
      ST_IDLE: begin
        // start is judged against loaded before any same-cycle write lands
        if (start && loaded_r) begin
          state_s = ST_SYNC;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SYNC: begin
        state_s  = ST_RUN;
        key_s    = sched_r[lock_next_s];
        mirror_s = lock_next_s;
      end
      ST_RUN: begin
        if (lock_phase != mirror_r) begin
          state_s = ST_FAULT;
          err_s   = 1'b1;
        end else if (stop) begin
          state_s = ST_IDLE;
        end else begin
          key_s    = sched_r[mirror_next_s];
          mirror_s = mirror_next_s;
        end
      end
      ST_FAULT: begin
        if (stop) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_FAULT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Control and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      key_r    <= {KEY_WIDTH{1'b0}};
      mirror_r <= {PHASE_W{1'b0}};
      err_r    <= 1'b0;
      mask_r   <= {NUM_PHASES{1'b0}};
      loaded_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      key_r    <= key_s;
      mirror_r <= mirror_s;
      err_r    <= err_s;
      mask_r   <= mask_s;
      loaded_r <= &mask_s;
    end
  end

  // Schedule storage, contents not cleared by reset
  always_ff @(posedge clock) begin
    if (!reset && wr_s) begin
      sched_r[cfg_index] <= cfg_key;
    end
  end

  assign cfg_ready = (state_r == ST_IDLE);
  assign running   = (state_r == ST_RUN);
  assign key_out   = key_r;
  assign loaded    = loaded_r;
  assign err       = err_r;

endmodule

// File: doc/cute_key_sequencer.md
Name: cute_key_sequencer

Overview:
- Upstream companion to the counter-locked (Cute-Lock style) benchmark cores.
- Holds a per-phase key schedule loaded over a valid/ready config port.
- Replays the schedule onto the core's keyinput bus, one entry per cycle, aligned to the core's free-running phase counter (Q_1,Q_0).
- Detects phase misalignment and blanks the key on fault.

Parameters:
- KEY_WIDTH, 3: width of the key bus; drives keyinput0..keyinput(KEY_WIDTH-1).
- NUM_PHASES, 4: schedule depth. Must equal the core's counter modulus and be a power of 2.
- PHASE_W, 2: log2(NUM_PHASES).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  config write accepted this cycle when high with cfg_valid.
- cfg_index  in  PHASE_W  schedule slot to write.
- cfg_key  in  KEY_WIDTH  key value for that slot.
- start  in  1  begin replay.
- stop  in  1  end replay, return to IDLE.
- lock_phase  in  PHASE_W  tap of the core's {Q_1,Q_0}.
- key_out  out  KEY_WIDTH  registered key. Bit i drives core keyinput i.
- running  out  1  high in RUN.
- loaded  out  1  all NUM_PHASES slots written since reset or clear.
- err  out  1  sticky phase-mismatch flag.

Behaviour:
- Reset (synchronous, active-high; takes priority over everything, including mid-RUN):
  - state=IDLE, key_out=0, running=0, loaded=0, err=0.
  - slot-written mask=0, mirror=0.
  - Schedule contents are don't-care after reset.
- States: IDLE, SYNC, RUN, FAULT.
- cfg_ready = (state==IDLE). A write occurs when cfg_valid & cfg_ready.
  - Slot cfg_index <= cfg_key; mask bit set.
  - loaded = &mask, registered; it is visible the cycle after the last write.
  - Rewriting a slot is allowed and keeps loaded high.
  - cfg_valid while not IDLE is ignored; no side effects.
- IDLE:
  - key_out=0.
  - start & loaded -> SYNC.
  - start & ~loaded: ignored, stay IDLE, no flag.
  - If cfg_valid and start occur in the same cycle, the write is taken and start is evaluated against the pre-write loaded.
- SYNC (1 cycle):
  - On the exit edge: key_out <= sched[lock_phase+1 mod NUM_PHASES]; mirror <= lock_phase+1; -> RUN.
  - No mismatch check in SYNC.
- RUN:
  - running=1.
  - Every edge: key_out <= sched[mirror+1]; mirror <= mirror+1 (wraps NUM_PHASES-1 -> 0).
  - Invariant: during any RUN cycle, key_out == sched[lock_phase].
  - Check each RUN cycle: if lock_phase != mirror -> FAULT on next edge, err<=1, key_out<=0.
  - stop -> IDLE on next edge, key_out<=0.
  - If stop and a mismatch occur in the same cycle, FAULT wins.
  - start in RUN is ignored.
- FAULT:
  - key_out=0, running=0, err=1, cfg_ready=0.
  - Left only via stop (-> IDLE, err stays 1) or reset (clears err).
  - From IDLE with err=1, start & loaded is permitted and re-syncs; err remains 1 until reset.
- Latency:
  - start to first valid key: 2 cycles (IDLE->SYNC edge, then SYNC->RUN edge).
  - stop to key_out=0: 1 cycle.
- Arithmetic: all phase arithmetic is modulo NUM_PHASES on PHASE_W bits; no saturation.
- The core's counter has no reset. The sequencer never assumes a lock_phase value; it aligns only through SYNC.

Test Plan:
- Reset, then write slots 0..3 = 3'b001, 3'b010, 3'b101, 3'b110 -> cfg_ready=1 throughout; loaded rises the cycle after the 4th write; key_out=0.
- start with lock_phase counting 2,3,0,1,... -> SYNC, then RUN. From the first RUN cycle key_out tracks lock_phase: 3'b110 at phase 3, 3'b001 at 0, 3'b010 at 1, 3'b101 at 2. err=0 over 100 cycles.
- Only slots 0..2 written, then start -> stays IDLE, running=0, key_out=0. Write slot 3, then start -> enters RUN.
- In RUN, hold lock_phase for one extra cycle (repeat a value) -> next cycle state FAULT, key_out=0, err=1. stop -> IDLE with err=1. reset -> err=0.
- In RUN, pulse cfg_valid with index 1, key 3'b111 -> cfg_ready=0 and slot 1 keeps 3'b010. Then stop -> key_out=0 next cycle and cfg_ready=1.
- Assert reset in mid-RUN at phase 2 -> next cycle key_out=0, running=0, loaded=0. A following start is ignored until all slots are reloaded.
